// File: rtl/if_id_rx_if.sv
// Fetch-to-decode bus for the IF/ID receive stage: fetch-side inputs plus registered decode-side outputs.
interface if_id_rx_if;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 16;

  logic [INSTR_W-1:0] instruction;
  logic [INSTR_W-1:0] Data;
  logic [PC_W-1:0]    PC_IF_out;
  logic               INT;
  logic               stall;
  logic               flush;

  logic [INSTR_W-1:0] instr_out;
  logic [INSTR_W-1:0] imm_out;
  logic [PC_W-1:0]    pc_out;
  logic               int_out;
  logic               valid_out;
  logic               busy;
  logic [CNT_W-1:0]   retired_cnt;
  logic               illegal_out;

  // Fetch side drives the word stream and control, observes the decode-side view.
  modport master (
    output instruction, Data, PC_IF_out, INT, stall, flush,
    input  instr_out, imm_out, pc_out, int_out, valid_out, busy, retired_cnt, illegal_out
  );

  modport slave (
    input  instruction, Data, PC_IF_out, INT, stall, flush,
    output instr_out, imm_out, pc_out, int_out, valid_out, busy, retired_cnt, illegal_out
  );
endinterface

// File: rtl/if_id_rx.sv
// IF/ID receive stage: assembles one- and two-word (I-type, opcode 8) instructions for decode.
// Optional macro IF_ID_RX_ILLEGAL_OP_EN flags opcodes D/E/F as illegal; otherwise they pass through.
module if_id_rx (
  input  logic        clk,
  input  logic        reset,
  if_id_rx_if.slave   bus
);
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 16;
  localparam logic [3:0]  OP_ITYPE = 4'd8;

  typedef enum logic [0:0] {
    OPCODE   = 1'b0,
    WAIT_IMM = 1'b1
  } state_e;

  state_e             state_q;
  logic [INSTR_W-1:0] hold_instr_q;
  logic [PC_W-1:0]    hold_pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] imm_q;
  logic [PC_W-1:0]    pc_q;
  logic               int_q;
  logic               valid_q;
  logic               busy_q;
  logic [CNT_W-1:0]   retired_q;
  logic [CNT_W-1:0]   retired_inc_d;
  logic               illegal_q;
  logic               opc_illegal;

  assign retired_inc_d = (retired_q == {CNT_W{1'b1}}) ? retired_q : retired_q + CNT_W'(1);

`ifdef IF_ID_RX_ILLEGAL_OP_EN
  assign opc_illegal = (bus.instruction[15:12] >= 4'hD);
`else
  assign opc_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= OPCODE;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      instr_q      <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      int_q        <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      retired_q    <= '0;
      illegal_q    <= 1'b0;
    end else if (bus.flush) begin
      state_q      <= OPCODE;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      instr_q      <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      int_q        <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.INT) begin
        // Interrupt marker wins over any half-assembled I-type word.
        state_q      <= OPCODE;
        hold_instr_q <= '0;
        hold_pc_q    <= '0;
        instr_q      <= '0;
        imm_q        <= '0;
        pc_q         <= bus.PC_IF_out;
        int_q        <= 1'b1;
        valid_q      <= 1'b0;
        busy_q       <= 1'b0;
        illegal_q    <= 1'b0;
      end else begin
        int_q     <= 1'b0;
        illegal_q <= 1'b0;
        case (state_q)
          OPCODE: begin
            imm_q <= '0;
            pc_q  <= bus.PC_IF_out;
            if (bus.instruction == '0) begin
              instr_q <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else if (bus.instruction[15:12] == OP_ITYPE) begin
              hold_instr_q <= bus.instruction;
              hold_pc_q    <= bus.PC_IF_out;
              state_q      <= WAIT_IMM;
              instr_q      <= '0;
              valid_q      <= 1'b0;
              busy_q       <= 1'b1;
            end else if (opc_illegal) begin
              instr_q   <= '0;
              valid_q   <= 1'b0;
              busy_q    <= 1'b0;
              illegal_q <= 1'b1;
            end else begin
              instr_q   <= bus.instruction;
              valid_q   <= 1'b1;
              busy_q    <= 1'b0;
              retired_q <= retired_inc_d;
            end
          end
          WAIT_IMM: begin
            // Data is taken as the immediate regardless of its top nibble.
            instr_q      <= hold_instr_q;
            imm_q        <= bus.Data;
            pc_q         <= hold_pc_q;
            valid_q      <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= OPCODE;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            retired_q    <= retired_inc_d;
          end
          default: begin
            state_q <= OPCODE;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.imm_out     = imm_q;
  assign bus.pc_out      = pc_q;
  assign bus.int_out     = int_q;
  assign bus.valid_out   = valid_q;
  assign bus.busy        = busy_q;
  assign bus.retired_cnt = retired_q;
  assign bus.illegal_out = illegal_q;
endmodule

// File: doc/if_id_rx.md
IF_ID_RX -- requirements
Module: if_id_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and reset. All state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 instruction  input  16  word from the fetch stage; 16'd0 is a NOP/bubble.
REQ-005 Data  input  16  raw fetched word, carrying the immediate in the cycle after an I-type opcode.
REQ-006 PC_IF_out  input  32  fetch-stage PC+1 accompanying the instruction.
REQ-007 INT  input  1  interrupt marker from fetch.
REQ-008 stall  input  1  hold all state.
REQ-009 flush  input  1  discard the in-flight word (jump, pop_pc, exception).
REQ-010 instr_out  output  16  instruction presented to decode.
REQ-011 imm_out  output  16  immediate for I-type; 16'd0 otherwise.
REQ-012 pc_out  output  32  PC associated with instr_out.
REQ-013 int_out  output  1  interrupt marker presented to decode.
REQ-014 valid_out  output  1  instr_out, imm_out and pc_out are a complete instruction.
REQ-015 busy  output  1  high while the FSM is in WAIT_IMM.
REQ-016 retired_cnt  output  16  count of valid_out cycles.
REQ-017 illegal_out  output  1  illegal-opcode flag (see Configuration).

Function
REQ-018 The FSM SHALL have exactly two states: OPCODE and WAIT_IMM. busy SHALL be 1 only in WAIT_IMM.
REQ-019 Priority on each edge: reset > flush > stall > INT > normal operation.
REQ-020 OPCODE, instruction[15:12]==4'd8: capture instruction and PC_IF_out into hold registers; next state WAIT_IMM; drive valid_out=0 and instr_out=0 (bubble).
REQ-021 OPCODE, other non-zero word: register instruction into instr_out and PC_IF_out into pc_out; imm_out=0; valid_out=1 on the next cycle. Latency is 1 cycle.
REQ-022 OPCODE, instruction==16'd0: valid_out=0 and instr_out=0.
REQ-023 WAIT_IMM: register Data into imm_out and the held word into instr_out; pc_out=held PC; valid_out=1; next state OPCODE. I-type latency is 2 cycles from the opcode word.
REQ-024 In WAIT_IMM, a Data word whose top nibble is 8 SHALL be treated as an immediate, not as an opcode.
REQ-025 INT=1 without stall or flush: int_out=1, instr_out=0, valid_out=0, next state OPCODE. Any WAIT_IMM capture in progress SHALL be abandoned.
REQ-026 flush=1: instr_out, imm_out and int_out =0; valid_out=0; next state OPCODE; hold registers cleared. Flush SHALL override a simultaneous stall.
REQ-027 stall=1 without flush: every output, the FSM state, the hold registers and retired_cnt SHALL keep their values.
REQ-028 retired_cnt SHALL increment by 1 on each edge that sets valid_out=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-029 Each output register SHALL be loaded once per non-stalled cycle; no output SHALL be combinational from inputs.

Reset
REQ-030 reset=1 at an edge SHALL force state OPCODE and set instr_out, imm_out, pc_out, int_out, valid_out, busy, illegal_out and retired_cnt to 0. Hold registers SHALL also be cleared.
REQ-031 Reset asserted mid-I-type (in WAIT_IMM) SHALL discard the held opcode. The first edge after reset deasserts SHALL treat instruction as an opcode.

Configuration
REQ-032 Macro IF_ID_RX_ILLEGAL_OP_EN.
- Defined: an opcode nibble of 4'hD, 4'hE or 4'hF seen in OPCODE state SHALL set illegal_out=1 for one cycle, replace instr_out with 16'd0 and set valid_out=0.
- Undefined: these opcodes pass through as normal words and illegal_out is tied to 0.

Verification
REQ-033 After reset, apply instruction=16'h1234, PC_IF_out=5 -> next cycle: instr_out=16'h1234, pc_out=5, valid_out=1, retired_cnt=1.
REQ-034 Apply 16'h8A00 then Data=16'h8BEE -> cycle 1: valid_out=0, busy=1; cycle 2: instr_out=16'h8A00, imm_out=16'h8BEE, valid_out=1, busy=0.
REQ-035 Apply 16'h8A00, then stall for 3 cycles, then Data=16'h0042 -> outputs frozen during the stall; then imm_out=16'h0042, valid_out=1.
REQ-036 Apply 16'h8A00, then flush=1 and stall=1 together -> state OPCODE, valid_out=0, busy=0, no retire.
REQ-037 Apply INT=1 while in WAIT_IMM -> int_out=1, valid_out=0, busy=0; the next word 16'h2001 is decoded as an opcode.
REQ-038 With IF_ID_RX_ILLEGAL_OP_EN defined, apply 16'hE000 -> illegal_out=1, valid_out=0. With the macro undefined -> instr_out=16'hE000, valid_out=1.
